mul_bus_master: RTL

Bus initiator for the two-operand multiplier peripheral. It accepts a multiply request on a simple start/done interface and sequences the peripheral bus: write operand A to address 0, write operand B to address 1, then read the product. It handles the ready handshake, a one-time operand clear after reset, and a timeout when the peripheral stalls. It sits between a controller (or test sequencer) and one multiplier peripheral.

---
 rtl/mul_bus_master.sv | 102 ++++++++++
 1 files changed

// File: rtl/mul_bus_master.sv
// Bus initiator for the two-operand multiplier peripheral: writes A to address 0,
// B to address 1, reads the product, with ready handshake, post-reset clear and timeout.
module mul_bus_master #(
    parameter int SZin = 8,
    parameter int TMO  = 16
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic [SZin-1:0]   op_a,
    input  logic [SZin-1:0]   op_b,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2*SZin-1:0] result,
    output logic              sel,
    output logic              wrt,
    output logic              addr_b,
    output logic [SZin-1:0]   wdata,
    output logic              bus_nres,
    input  logic              ready,
    input  logic [2*SZin-1:0] rdata
);
    localparam int CNT_W = $clog2(TMO + 1);

    typedef enum logic [3:0] {
        CLR, IDLE, WR_A, GAP_A, WR_B, GAP_B, RD, DONE, ERR
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [SZin-1:0]  opb_r;
    logic             access;
    logic             qual;
    logic             expired;

    // The first edge of an access ignores ready: it may be left over from the previous access.
    assign access  = (state == WR_A) || (state == WR_B) || (state == RD);
    assign qual    = access && (cnt != '0) && ready;
    assign expired = access && !qual && (cnt == CNT_W'(TMO - 1));

    always_comb begin
        state_n = state;
        case (state)
            CLR:   state_n = IDLE;
            IDLE:  if (start) state_n = WR_A;
            WR_A:  if (qual) state_n = GAP_A; else if (expired) state_n = ERR;
            GAP_A: state_n = WR_B;
            WR_B:  if (qual) state_n = GAP_B; else if (expired) state_n = ERR;
            GAP_B: state_n = RD;
            RD:    if (qual) state_n = DONE; else if (expired) state_n = ERR;
            DONE:  state_n = IDLE;
            ERR:   state_n = IDLE;
            default: state_n = CLR;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state    <= CLR;
            cnt      <= '0;
            sel      <= 1'b1;
            wrt      <= 1'b0;
            addr_b   <= 1'b0;
            wdata    <= '0;
            bus_nres <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            result   <= '0;
        end else begin
            state    <= state_n;
            cnt      <= (access && state_n == state) ? cnt + CNT_W'(1) : '0;
            sel      <= (state_n == WR_A) || (state_n == WR_B) || (state_n == RD);
            wrt      <= (state_n == WR_A) || (state_n == WR_B);
            bus_nres <= 1'b1;
            busy     <= (state_n != IDLE);
            done     <= (state_n == DONE);
            err      <= (state_n == ERR);
            if (state == IDLE && start) begin
                addr_b <= 1'b0;
                wdata  <= op_a;
            end
            if (state == GAP_A) begin
                addr_b <= 1'b1;
                wdata  <= opb_r;
            end
            if (state == RD && qual) begin
                result <= rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            opb_r <= op_b;
        end
    end

endmodule
